// File: rtl/rf_write_arbiter_if.sv
// Writeback request channels (ALU and load) plus the register-file write port.
// The arbiter connects through the slave modport; requesters and the register file use master.
interface rf_write_arbiter_if #(
   parameter int DEST_W = 4,
   parameter int DATA_W = 8
);
   logic              alu_valid;
   logic [DEST_W-1:0] alu_dest;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [DEST_W-1:0] mem_dest;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              RegWrite;
   logic [DEST_W-1:0] destination;
   logic [DATA_W-1:0] write_data;
   logic              init_done;
   logic              bad_dest;

   modport slave (
      input  alu_valid, alu_dest, alu_data,
      input  mem_valid, mem_dest, mem_data,
      output alu_ready, mem_ready,
      output RegWrite, destination, write_data, init_done, bad_dest
   );

   modport master (
      output alu_valid, alu_dest, alu_data,
      output mem_valid, mem_dest, mem_data,
      input  alu_ready, mem_ready,
      input  RegWrite, destination, write_data, init_done, bad_dest
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: zero-fills every register after reset, then
// round-robins the port between ALU and load writebacks with one-cycle latency.
module rf_write_arbiter #(
   parameter int                NUM_REGS   = 12,
   parameter int                DEST_W     = 4,
   parameter int                DATA_W     = 8,
   parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00
) (
   input logic               clk,
   input logic               reset,
   rf_write_arbiter_if.slave bus
);
   localparam logic [0:0]        ST_INIT   = 1'b0;
   localparam logic [0:0]        ST_RUN    = 1'b1;
   localparam logic [DEST_W-1:0] LAST_IDX  = DEST_W'(NUM_REGS - 1);
   localparam logic [DEST_W:0]   REG_LIMIT = (DEST_W + 1)'(NUM_REGS);

   logic [0:0]        state_q,    state_d;
   logic [DEST_W-1:0] initCnt_q,  initCnt_d;
   logic              rrPtr_q,    rrPtr_d;
   logic              regWrite_q, regWrite_d;
   logic [DEST_W-1:0] dest_q,     dest_d;
   logic [DATA_W-1:0] data_q,     data_d;
   logic              initDone_q, initDone_d;
   logic              badDest_q,  badDest_d;

   logic              grantAlu;
   logic              grantMem;
   logic [DEST_W-1:0] selDest;
   logic [DATA_W-1:0] selData;

   // A lone requester always wins; on a tie rrPtr_q picks (0 favours the ALU).
   always_comb begin
      grantAlu = 1'b0;
      grantMem = 1'b0;
      if (state_q == ST_RUN) begin
         grantAlu = bus.alu_valid && (!bus.mem_valid || !rrPtr_q);
         grantMem = bus.mem_valid && (!bus.alu_valid ||  rrPtr_q);
      end
   end

   assign bus.alu_ready = grantAlu;
   assign bus.mem_ready = grantMem;
   assign selDest       = grantAlu ? bus.alu_dest : bus.mem_dest;
   assign selData       = grantAlu ? bus.alu_data : bus.mem_data;

   always_comb begin
      state_d    = state_q;
      initCnt_d  = initCnt_q;
      rrPtr_d    = rrPtr_q;
      regWrite_d = 1'b0;
      dest_d     = dest_q;
      data_d     = data_q;
      initDone_d = initDone_q;
      badDest_d  = 1'b0;
      case (state_q)
         ST_INIT: begin
            regWrite_d = 1'b1;
            dest_d     = initCnt_q;
            data_d     = INIT_VALUE;
            initCnt_d  = initCnt_q + 1'b1;
            if (initCnt_q == LAST_IDX) begin
               state_d    = ST_RUN;
               initDone_d = 1'b1;
            end
         end
         default: begin
            // Out-of-range destinations still complete the handshake but never reach the port.
            if (grantAlu || grantMem) begin
               rrPtr_d = grantAlu;
               if ({1'b0, selDest} < REG_LIMIT) begin
                  regWrite_d = 1'b1;
                  dest_d     = selDest;
                  data_d     = selData;
               end else begin
                  badDest_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         initCnt_q  <= '0;
         rrPtr_q    <= 1'b0;
         regWrite_q <= 1'b0;
         dest_q     <= '0;
         data_q     <= '0;
         initDone_q <= 1'b0;
         badDest_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         initCnt_q  <= initCnt_d;
         rrPtr_q    <= rrPtr_d;
         regWrite_q <= regWrite_d;
         dest_q     <= dest_d;
         data_q     <= data_d;
         initDone_q <= initDone_d;
         badDest_q  <= badDest_d;
      end
   end

   assign bus.RegWrite    = regWrite_q;
   assign bus.destination = dest_q;
   assign bus.write_data  = data_q;
   assign bus.init_done   = initDone_q;
   assign bus.bad_dest    = badDest_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected write-port contents are queued when a
// request is driven and compared one cycle later when the port should show them.
module tb_rf_write_arbiter;
   logic clk;
   logic reset;

   typedef struct packed {
      logic       regWrite;
      logic [3:0] dest;
      logic [7:0] data;
      logic       bad;
      logic       initDone;
      logic       chk;
   } exp_t;

   exp_t expQ[$];
   int   vectors;
   int   miscompares;
   bit   running;

   rf_write_arbiter_if #(.DEST_W(4), .DATA_W(8)) bus ();

   rf_write_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // Pops the entry for the current cycle and compares the registered write port.
   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = expQ.pop_front();
         checkVal("RegWrite", {7'd0, bus.RegWrite}, {7'd0, e.regWrite});
         checkVal("bad_dest", {7'd0, bus.bad_dest}, {7'd0, e.bad});
         checkVal("init_done", {7'd0, bus.init_done}, {7'd0, e.initDone});
         if (e.chk) begin
            checkVal("destination", {4'd0, bus.destination}, {4'd0, e.dest});
            checkVal("write_data", bus.write_data, e.data);
         end
      end
   endtask

   // Drives one cycle of inputs, checks readies and the port, queues next-cycle expectation.
   task automatic applyStimulus(input logic rst,
                                input logic aV, input logic [3:0] aD, input logic [7:0] aX,
                                input logic mV, input logic [3:0] mD, input logic [7:0] mX,
                                input logic eA, input logic eM);
      exp_t n;
      reset         = rst;
      bus.alu_valid = aV;
      bus.alu_dest  = aD;
      bus.alu_data  = aX;
      bus.mem_valid = mV;
      bus.mem_dest  = mD;
      bus.mem_data  = mX;
      @(negedge clk);
      checkVal("alu_ready", {7'd0, bus.alu_ready}, {7'd0, eA});
      checkVal("mem_ready", {7'd0, bus.mem_ready}, {7'd0, eM});
      checkOutput();
      n = '0;
      if (rst) begin
         n.chk = 1'b1;
         expQ.push_back(n);
      end else if (running) begin
         n.initDone = 1'b1;
         if (eA || eM) begin
            n.dest     = eA ? aD : mD;
            n.data     = eA ? aX : mX;
            n.regWrite = (n.dest < 4'd12);
            n.bad      = !n.regWrite;
            n.chk      = n.regWrite;
         end
         expQ.push_back(n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
   endtask

   // Both valids are held high throughout the sweep; neither may be granted.
   task automatic initSweep();
      exp_t n;
      running = 1'b0;
      for (int i = 0; i < 12; i++) begin
         n          = '0;
         n.regWrite = 1'b1;
         n.dest     = 4'(i);
         n.data     = 8'h00;
         n.initDone = (i == 11);
         n.chk      = 1'b1;
         expQ.push_back(n);
      end
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b0, 1'b1, 4'd9, 8'hEE, 1'b1, 4'd8, 8'hDD, 1'b0, 1'b0);
      running = 1'b1;
   endtask

   initial begin
      exp_t r;
      vectors       = 0;
      miscompares   = 0;
      running       = 1'b0;
      reset         = 1'b1;
      bus.alu_valid = 1'b0;
      bus.alu_dest  = '0;
      bus.alu_data  = '0;
      bus.mem_valid = 1'b0;
      bus.mem_dest  = '0;
      bus.mem_data  = '0;
      @(posedge clk);
      #1;
      r     = '0;
      r.chk = 1'b1;
      expQ.push_back(r);
      applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      initSweep();

      applyStimulus(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
      idle();
      idle();

      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 8'h33, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 4'd1, 8'h44, 1'b1, 4'd6, 8'h55, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd2, 8'h11, 1'b1, 4'd6, 8'h55, 1'b0, 1'b1);

      applyStimulus(1'b0, 1'b1, 4'd2, 8'h11, 1'b1, 4'd5, 8'h22, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd2, 8'h11, 1'b1, 4'd5, 8'h22, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 4'd2, 8'h11, 1'b1, 4'd5, 8'h22, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd2, 8'h11, 1'b1, 4'd5, 8'h22, 1'b0, 1'b1);
      idle();

      applyStimulus(1'b0, 1'b1, 4'd12, 8'h77, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
      idle();
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 8'h88, 1'b0, 1'b1);
      idle();
      idle();

      applyStimulus(1'b0, 1'b1, 4'd9, 8'h01, 1'b1, 4'd9, 8'h02, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 8'h02, 1'b0, 1'b1);
      idle();

      // Reset lands on the same edge as the accept, so the write must never appear.
      applyStimulus(1'b1, 1'b1, 4'd7, 8'h99, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      initSweep();
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
